// File: rtl/alu_ctrl_dec_pipe_if.sv
// Handshake bundle for alu_ctrl_dec_pipe: the upstream instruction channel and
// the downstream decoded-entry channel.
interface alu_ctrl_dec_pipe_if #(
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_alu_ctrl;
    logic [1:0]        out_src_a;
    logic              out_src_b;
    logic              out_word;
    logic              out_illegal;
    logic [31:0]       out_inst;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_alu_ctrl, out_src_a, out_src_b,
               out_word, out_illegal, out_inst
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_alu_ctrl, out_src_a, out_src_b,
               out_word, out_illegal, out_inst
    );
endinterface

// File: rtl/alu_ctrl_dec_pipe.sv
// Registered RV32I/RV64I ALU-control decoder behind a 2-entry skid buffer.
// Optional macro ALU_CTRL_MEXT_EN adds M-extension decode (needs CTRL_W >= 5).
module alu_ctrl_dec_pipe #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    alu_ctrl_dec_pipe_if.slave  bus
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("alu_ctrl_dec_pipe: XLEN must be 32 or 64");
    end
    if (CTRL_W < 4) begin : g_bad_ctrl_w
        $error("alu_ctrl_dec_pipe: CTRL_W must be at least 4");
    end
`ifdef ALU_CTRL_MEXT_EN
    if (CTRL_W < 5) begin : g_bad_ctrl_w_mext
        $error("alu_ctrl_dec_pipe: ALU_CTRL_MEXT_EN needs CTRL_W >= 5");
    end
`endif

    localparam bit RV64 = (XLEN == 64);

    localparam logic [4:0] OP_ADD      = 5'd0;
    localparam logic [4:0] OP_PASSB    = 5'd1;
    localparam logic [4:0] OP_ADD_CLR0 = 5'd3;
    localparam logic [4:0] OP_SLTU     = 5'd4;
    localparam logic [4:0] OP_XOR      = 5'd5;
    localparam logic [4:0] OP_OR       = 5'd6;
    localparam logic [4:0] OP_AND      = 5'd7;
    localparam logic [4:0] OP_SLL      = 5'd8;
    localparam logic [4:0] OP_SRL      = 5'd9;
    localparam logic [4:0] OP_SRA      = 5'd10;
    localparam logic [4:0] OP_SUB      = 5'd11;
    localparam logic [4:0] OP_SLT      = 5'd12;

    localparam logic [1:0] SRC_RS1  = 2'b00;
    localparam logic [1:0] SRC_PC   = 2'b01;
    localparam logic [1:0] SRC_ZERO = 2'b10;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [1:0]        src_a;
        logic              src_b;
        logic              word;
        logic              illegal;
        logic [31:0]       inst;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] hi6;
    logic       sll_imm_ok;
    logic       sr_imm_ok;
    logic [4:0] code;
    logic [1:0] sa;
    logic       sb;
    logic       wd;
    logic       ill;
    entry_t     dec;

    assign opcode = bus.in_inst[6:0];
    assign f3     = bus.in_inst[14:12];
    assign f7     = bus.in_inst[31:25];
    assign hi6    = bus.in_inst[31:26];

    // RV64 immediate shifts borrow inst[25] as shamt[5]; RV32 must keep it clear.
    assign sll_imm_ok = RV64 ? (hi6 == 6'b000000) : (f7 == 7'b0000000);
    assign sr_imm_ok  = RV64 ? (hi6 == 6'b000000 || hi6 == 6'b010000)
                             : (f7 == 7'b0000000 || f7 == 7'b0100000);

    always_comb begin
        code = OP_ADD;
        sa   = SRC_RS1;
        sb   = 1'b0;
        wd   = 1'b0;
        ill  = 1'b0;
        case (opcode)
            OPC_LUI:   begin code = OP_PASSB; sa = SRC_ZERO; sb = 1'b1; end
            OPC_AUIPC: begin sa = SRC_PC; sb = 1'b1; end
            OPC_JAL:   begin sa = SRC_PC; sb = 1'b1; end
            OPC_JALR:  begin code = OP_ADD_CLR0; sb = 1'b1; ill = (f3 != 3'b000); end
            OPC_BRANCH: begin
                case (f3)
                    3'b000, 3'b001: code = OP_SUB;
                    3'b100, 3'b101: code = OP_SLT;
                    3'b110, 3'b111: code = OP_SLTU;
                    default:        ill  = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                sb = 1'b1;
                case (f3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ill = 1'b0;
                    3'b011, 3'b110:                         ill = !RV64;
                    default:                                ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                sb = 1'b1;
                case (f3)
                    3'b000, 3'b001, 3'b010: ill = 1'b0;
                    3'b011:                 ill = !RV64;
                    default:                ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                sb = 1'b1;
                case (f3)
                    3'b000: code = OP_ADD;
                    3'b010: code = OP_SLT;
                    3'b011: code = OP_SLTU;
                    3'b100: code = OP_XOR;
                    3'b110: code = OP_OR;
                    3'b111: code = OP_AND;
                    3'b001: begin code = OP_SLL; ill = !sll_imm_ok; end
                    default: begin
                        code = bus.in_inst[30] ? OP_SRA : OP_SRL;
                        ill  = !sr_imm_ok;
                    end
                endcase
            end
            OPC_OP: begin
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  code = OP_ADD;
                            3'b001:  code = OP_SLL;
                            3'b010:  code = OP_SLT;
                            3'b011:  code = OP_SLTU;
                            3'b100:  code = OP_XOR;
                            3'b101:  code = OP_SRL;
                            3'b110:  code = OP_OR;
                            default: code = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3)
                            3'b000:  code = OP_SUB;
                            3'b101:  code = OP_SRA;
                            default: ill  = 1'b1;
                        endcase
                    end
`ifdef ALU_CTRL_MEXT_EN
                    // M-extension codes are 16 + funct3 (MUL..REMU).
                    7'b0000001: code = {2'b10, f3};
`endif
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP_IMM32: begin
                sb = 1'b1;
                wd = 1'b1;
                case (f3)
                    3'b000:  code = OP_ADD;
                    3'b001:  begin code = OP_SLL; ill = (f7 != 7'b0000000); end
                    3'b101:  begin
                        code = bus.in_inst[30] ? OP_SRA : OP_SRL;
                        ill  = (f7 != 7'b0000000 && f7 != 7'b0100000);
                    end
                    default: ill = 1'b1;
                endcase
                if (!RV64) ill = 1'b1;
            end
            OPC_OP32: begin
                wd = 1'b1;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  code = OP_ADD;
                            3'b001:  code = OP_SLL;
                            3'b101:  code = OP_SRL;
                            default: ill  = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3)
                            3'b000:  code = OP_SUB;
                            3'b101:  code = OP_SRA;
                            default: ill  = 1'b1;
                        endcase
                    end
`ifdef ALU_CTRL_MEXT_EN
                    7'b0000001: begin
                        code = {2'b10, f3};
                        ill  = (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011);
                    end
`endif
                    default: ill = 1'b1;
                endcase
                if (!RV64) ill = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: code = OP_ADD;
            default: ill = 1'b1;
        endcase
        if (ill) begin
            code = OP_ADD;
            sa   = SRC_RS1;
            sb   = 1'b0;
            wd   = 1'b0;
        end
    end

    assign dec = '{ctrl: CTRL_W'(code), src_a: sa, src_b: sb, word: wd,
                   illegal: ill, inst: bus.in_inst};

    state_t state;
    state_t next_state;
    entry_t m_q;
    entry_t s_q;
    logic   in_ready_q;
    logic   acc;
    logic   drn;
    logic   load_m_dec;
    logic   load_m_skid;
    logic   load_s;

    assign acc = bus.in_valid & in_ready_q;
    assign drn = (state != EMPTY) & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state != FULL);
        end
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY:   if (acc) next_state = ONE;
                ONE: begin
                    if (acc && !drn)      next_state = FULL;
                    else if (!acc && drn) next_state = EMPTY;
                end
                FULL:    if (drn) next_state = ONE;
                default: next_state = EMPTY;
            endcase
        end
    end

    // A flush suppresses every data load so a same-cycle accept is discarded.
    always_comb begin
        load_m_dec  = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        if (!flush) begin
            case (state)
                EMPTY: load_m_dec = acc;
                ONE: begin
                    load_m_dec = acc & drn;
                    load_s     = acc & !drn;
                end
                FULL:    load_m_skid = drn;
                default: load_m_dec = 1'b0;
            endcase
        end
        bus.in_ready     = in_ready_q;
        bus.out_valid    = (state != EMPTY);
        bus.out_alu_ctrl = m_q.ctrl;
        bus.out_src_a    = m_q.src_a;
        bus.out_src_b    = m_q.src_b;
        bus.out_word     = m_q.word;
        bus.out_illegal  = m_q.illegal;
        bus.out_inst     = m_q.inst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (load_m_dec)       m_q <= dec;
            else if (load_m_skid) m_q <= s_q;
            if (load_s)           s_q <= dec;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_dec_pipe.sv
// Self-checking bench for alu_ctrl_dec_pipe: an XLEN=32 and an XLEN=64 instance,
// table-driven decode vectors plus hand-written handshake sequences.
`timescale 1ns/1ps
module tb_alu_ctrl_dec_pipe;
`ifdef ALU_CTRL_MEXT_EN
    localparam int CW   = 5;
    localparam bit MEXT = 1'b1;
`else
    localparam int CW   = 4;
    localparam bit MEXT = 1'b0;
`endif

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] ANDI = 32'h0070F093;
    localparam logic [31:0] ORI  = 32'h0060E093;
    localparam logic [31:0] XORI = 32'h0030C093;

    typedef struct {
        string       name;
        logic [31:0] inst;
        int          ctrl;
        logic [1:0]  src_a;
        logic        src_b;
        logic        word;
        logic        ill;
    } vec_t;

    logic clk;
    logic rst;
    logic flush;
    int   n_total;
    int   n_bad;
    vec_t v32[$];
    vec_t v64[$];

    alu_ctrl_dec_pipe_if #(.CTRL_W(CW)) bus32 ();
    alu_ctrl_dec_pipe_if #(.CTRL_W(CW)) bus64 ();

    alu_ctrl_dec_pipe #(.XLEN(32), .CTRL_W(CW)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus32)
    );
    alu_ctrl_dec_pipe #(.XLEN(64), .CTRL_W(CW)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus64)
    );

    always #5 clk = ~clk;

    function automatic void add(ref vec_t q[$], input string name, input logic [31:0] inst,
                                input int ctrl, input logic [1:0] a, input logic b,
                                input logic w, input logic ill);
        vec_t v;
        v.name = name; v.inst = inst; v.ctrl = ill ? 0 : ctrl;
        v.src_a = ill ? 2'b00 : a; v.src_b = ill ? 1'b0 : b;
        v.word = ill ? 1'b0 : w; v.ill = ill;
        q.push_back(v);
    endfunction

    function automatic logic [45:0] pack(input logic valid, input int ctrl, input logic [1:0] a,
                                         input logic b, input logic w, input logic ill,
                                         input logic [31:0] inst);
        return {valid, 8'(ctrl), a, b, w, ill, inst};
    endfunction

    function automatic logic [45:0] act32();
        return {bus32.out_valid, 8'(bus32.out_alu_ctrl), bus32.out_src_a, bus32.out_src_b,
                bus32.out_word, bus32.out_illegal, bus32.out_inst};
    endfunction

    function automatic logic [45:0] act64();
        return {bus64.out_valid, 8'(bus64.out_alu_ctrl), bus64.out_src_a, bus64.out_src_b,
                bus64.out_word, bus64.out_illegal, bus64.out_inst};
    endfunction

    task automatic checkOutput(input string name, input logic [45:0] actual,
                               input logic [45:0] expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                                 input logic ordy, input logic fl);
        bus32.in_valid  = valid;
        bus32.in_inst   = inst;
        bus32.out_ready = ordy;
        flush           = fl;
    endtask

    task automatic fillFull();
        applyStimulus(1'b1, ANDI, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, ORI, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        clk     = 1'b0;
        rst     = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        bus64.in_valid  = 1'b0;
        bus64.in_inst   = 32'h0;
        bus64.out_ready = 1'b1;

        add(v32, "addi",   ADDI,         0,  2'b00, 1'b1, 1'b0, 1'b0);
        add(v32, "lui",    32'h123450B7, 1,  2'b10, 1'b1, 1'b0, 1'b0);
        add(v32, "jalr",   32'h000080E7, 3,  2'b00, 1'b1, 1'b0, 1'b0);
        add(v32, "sltiu",  32'h0010B113, 4,  2'b00, 1'b1, 1'b0, 1'b0);
        add(v32, "srai",   32'h4020D193, 10, 2'b00, 1'b1, 1'b0, 1'b0);
        add(v32, "auipc",  32'h00000097, 0,  2'b01, 1'b1, 1'b0, 1'b0);
        add(v32, "jal",    32'h008000EF, 0,  2'b01, 1'b1, 1'b0, 1'b0);
        add(v32, "beq",    32'h00208463, 11, 2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "blt",    32'h0020C463, 12, 2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "bgeu",   32'h0020F463, 4,  2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "lw",     32'h0000A083, 0,  2'b00, 1'b1, 1'b0, 1'b0);
        add(v32, "sw",     32'h0010A023, 0,  2'b00, 1'b1, 1'b0, 1'b0);
        add(v32, "ld32",   32'h0000B083, 0,  2'b00, 1'b1, 1'b0, 1'b1);
        add(v32, "sub",    32'h402080B3, 11, 2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "sra",    32'h4020D0B3, 10, 2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "xor",    32'h0020C0B3, 5,  2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "or",     32'h0020E0B3, 6,  2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "and",    32'h0020F0B3, 7,  2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "sll",    32'h002090B3, 8,  2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "srl",    32'h0020D0B3, 9,  2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "slt",    32'h0020A0B3, 12, 2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "sltu",   32'h0020B0B3, 4,  2'b00, 1'b0, 1'b0, 1'b0);
        add(v32, "badf7",  32'h202080B3, 0,  2'b00, 1'b0, 1'b0, 1'b1);
        add(v32, "slli25", 32'h02009093, 0,  2'b00, 1'b1, 1'b0, 1'b1);
        add(v32, "opc7f",  32'h0000007F, 0,  2'b00, 1'b0, 1'b0, 1'b1);
        add(v32, "addiw32",32'h0010809B, 0,  2'b00, 1'b1, 1'b1, 1'b1);
        add(v32, "mul",    32'h022080B3, 16, 2'b00, 1'b0, 1'b0, !MEXT);
        add(v32, "divu",   32'h0220D0B3, 21, 2'b00, 1'b0, 1'b0, !MEXT);

        add(v64, "slli64", 32'h02009093, 8,  2'b00, 1'b1, 1'b0, 1'b0);
        add(v64, "slli26", 32'h04009093, 0,  2'b00, 1'b1, 1'b0, 1'b1);
        add(v64, "addiw",  32'h0010809B, 0,  2'b00, 1'b1, 1'b1, 1'b0);
        add(v64, "ld64",   32'h0000B083, 0,  2'b00, 1'b1, 1'b0, 1'b0);
        add(v64, "sraiw",  32'h4020D19B, 10, 2'b00, 1'b1, 1'b1, 1'b0);
        add(v64, "sraiw25",32'h0220D19B, 0,  2'b00, 1'b1, 1'b1, 1'b1);
        add(v64, "subw",   32'h402080BB, 11, 2'b00, 1'b0, 1'b1, 1'b0);
        add(v64, "lui64",  32'h123450B7, 1,  2'b10, 1'b1, 1'b0, 1'b0);
        add(v64, "mulw",   32'h022080BB, 16, 2'b00, 1'b0, 1'b1, !MEXT);

        #2;
        checkOutput("rst32_out", act32(), pack(1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0));
        checkOutput("rst32_rdy", 46'(bus32.in_ready), 46'(1));
        checkOutput("rst64_out", act64(), pack(1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (v32[i]) begin
            applyStimulus(1'b1, v32[i].inst, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput(v32[i].name, act32(), pack(1'b1, v32[i].ctrl, v32[i].src_a,
                        v32[i].src_b, v32[i].word, v32[i].ill, v32[i].inst));
            checkOutput({v32[i].name, "_rdy"}, 46'(bus32.in_ready), 46'(1));
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("stream_drain", 46'(bus32.out_valid), 46'(0));

        foreach (v64[i]) begin
            bus64.in_valid = 1'b1;
            bus64.in_inst  = v64[i].inst;
            @(negedge clk);
            checkOutput(v64[i].name, act64(), pack(1'b1, v64[i].ctrl, v64[i].src_a,
                        v64[i].src_b, v64[i].word, v64[i].ill, v64[i].inst));
        end
        bus64.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("drain64", 46'(bus64.out_valid), 46'(0));

        applyStimulus(1'b1, ANDI, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_one", act32(), pack(1'b1, 7, 2'b00, 1'b1, 1'b0, 1'b0, ANDI));
        checkOutput("bp_one_rdy", 46'(bus32.in_ready), 46'(1));
        applyStimulus(1'b1, ORI, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_full_hold", act32(), pack(1'b1, 7, 2'b00, 1'b1, 1'b0, 1'b0, ANDI));
        checkOutput("bp_full_rdy", 46'(bus32.in_ready), 46'(0));
        applyStimulus(1'b1, XORI, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_stall_hold", act32(), pack(1'b1, 7, 2'b00, 1'b1, 1'b0, 1'b0, ANDI));
        checkOutput("bp_stall_rdy", 46'(bus32.in_ready), 46'(0));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bp_skid_out", act32(), pack(1'b1, 6, 2'b00, 1'b1, 1'b0, 1'b0, ORI));
        checkOutput("bp_skid_rdy", 46'(bus32.in_ready), 46'(1));
        @(negedge clk);
        checkOutput("bp_empty", 46'(bus32.out_valid), 46'(0));

        fillFull();
        checkOutput("fl_full_rdy", 46'(bus32.in_ready), 46'(0));
        applyStimulus(1'b1, XORI, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("fl_valid", 46'(bus32.out_valid), 46'(0));
        checkOutput("fl_rdy", 46'(bus32.in_ready), 46'(1));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("fl_no_stale", 46'(bus32.out_valid), 46'(0));
        end

        applyStimulus(1'b1, ANDI, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, XORI, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("fl_one_acc", 46'(bus32.out_valid), 46'(0));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("fl_one_after", 46'(bus32.out_valid), 46'(0));

        fillFull();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_full_out", act32(), pack(1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0));
        checkOutput("rst_full_rdy", 46'(bus32.in_ready), 46'(1));
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, ADDI, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rst_addi", act32(), pack(1'b1, 0, 2'b00, 1'b1, 1'b0, 1'b0, ADDI));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rst_drain", 46'(bus32.out_valid), 46'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_dec_pipe.md
Name: alu_ctrl_dec_pipe

Overview:
Registered, handshaked successor to the combinational ALU-control decoder. It decodes every RV32I/RV64I integer opcode class into an ALU operation code plus operand-select and illegal flags. Output is buffered in a 2-entry skid register so the decode stage breaks the IFU→EXU timing path with full valid/ready throughput. Sits between instruction fetch and the execute unit in npc.

Parameters:
XLEN, 32, datapath width; 32 or 64; 64 enables RV64 loads/stores (ld/lwu/sd), OP-IMM-32/OP-32 and 6-bit shamt.
CTRL_W, 4, alu_ctrl width; must be ≥5 when ALU_CTRL_MEXT_EN is defined.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous discard of all buffered entries
in_valid  in  1  upstream instruction valid
in_ready  out  1  registered; high when the skid entry is free
in_inst  in  32  instruction word
out_valid  out  1  decoded entry available
out_ready  in  1  downstream accepts entry
out_alu_ctrl  out  CTRL_W  ALU operation code
out_src_a  out  2  00 rs1, 01 pc, 10 zero
out_src_b  out  1  0 rs2, 1 imm
out_word  out  1  RV64 W-op (result sign-extended from bit 31); always 0 when XLEN=32
out_illegal  out  1  unrecognised encoding
out_inst  out  32  instruction passed through with its decode

Behaviour:
- Op codes (zero-extended to CTRL_W): 0 ADD, 1 PASSB, 3 ADD_CLR0 (jalr target, bit0 cleared), 4 SLTU, 5 XOR, 6 OR, 7 AND, 8 SLL, 9 SRL, 10 SRA, 11 SUB, 12 SLT. Code 2 is unused.
- Decode: auipc ADD a=pc b=imm; lui PASSB a=zero b=imm; jal ADD a=pc b=imm; jalr (f3=000) ADD_CLR0 a=rs1 b=imm.
- Loads and stores: ADD a=rs1 b=imm.
- Branches use b=rs2: beq/bne SUB; blt/bge SLT; bltu/bgeu SLTU.
- OP-IMM: addi ADD, slti SLT, sltiu SLTU, xori XOR, ori OR, andi AND, slli SLL, srli SRL, srai SRA.
- OP, with funct7 0000000 or 0100000: add/sub ADD/SUB, sll, slt, sltu, xor, srl/sra, or, and.
- MISC-MEM and SYSTEM: ADD, legal.
- Illegal shift encodings:
  - XLEN=32: inst[25]=1 on an immediate shift.
  - XLEN=64: inst[31:26] not 000000/010000.
  - W-shifts: inst[25]=1.
  - Bad funct7 on OP.
- Illegal load/store funct3, including RV64-only funct3 when XLEN=32.
- Any other opcode is illegal.
- Illegal entries: alu_ctrl=0, src_a=00, src_b=0, word=0, illegal=1. Illegal entries still flow through the handshake.
- Buffer states, with main register M and skid register S: EMPTY, ONE (M valid), FULL (M and S valid).
- out_valid = (state≠EMPTY). Outputs always driven from M.
- in_ready is registered: 1 in EMPTY/ONE, 0 in FULL.
- Let acc = in_valid & in_ready and drn = out_valid & out_ready.
  - EMPTY, acc → ONE; M←decode(in).
  - ONE, acc & !drn → FULL; S←decode(in).
  - ONE, acc & drn → ONE; M←decode(in).
  - ONE, !acc & drn → EMPTY.
  - FULL, drn → ONE; M←S. No accept is possible in FULL.
- Latency: an instruction accepted in cycle N is visible on out_* in cycle N+1.
- Throughput is 1/cycle when out_ready stays high.
- While out_valid & !out_ready, all out_* stay stable.
- flush: next state EMPTY and in_ready=1. A same-cycle acc is discarded. flush has priority over every transition.
- Reset (async assert; deassert synchronised externally): state EMPTY, in_ready=1, out_valid=0, all other outputs 0.
- Reset mid-transfer drops M and S contents.

Optional Feature:
- Macro: ALU_CTRL_MEXT_EN.
- Defined: decodes M extension (OP with funct7=0000001) into codes 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - When XLEN=64, mulw/divw/divuw/remw/remuw are also decoded, with out_word=1.
  - Elaboration error if CTRL_W<5.
- Undefined: funct7=0000001 on OP/OP-32 decodes as illegal.

Test Plan:
1. Reset asserted mid-FULL → same cycle out_valid=0, in_ready=1, out_alu_ctrl=0; after release, first accepted 0x00500093 (addi) appears next cycle with ctrl=0, src_a=00, src_b=1.
2. Streaming, out_ready=1: lui 0x123450B7, jalr 0x000080E7, sltiu 0x0010B113, srai 0x4020D193 on consecutive cycles → out ctrl 1,3,4,10 on consecutive cycles; in_ready never drops.
3. Backpressure: out_ready=0, send andi then ori → after 2 cycles FULL, in_ready=0, out holds andi (ctrl 7); raise out_ready → ori (6) next cycle, then EMPTY.
4. Flush in FULL with in_valid=1 → next cycle out_valid=0, in_ready=1; no stale entry ever emerges.
5. XLEN=32: slli with inst[25]=1 (0x02009093) and opcode 0x7F → illegal=1, ctrl=0; XLEN=64: same slli legal, ctrl=8; addiw 0x0010809B → ctrl=0, word=1.
6. ALU_CTRL_MEXT_EN, CTRL_W=5: mul 0x022080B3 → ctrl=16; divu 0x0220D0B3 → ctrl=21. Macro undefined: mul → illegal=1.
